memory_stage: RTL and testbench

Load/store stage of the RISC-V pipeline, placed directly after the execute stage. Consumes the memory request execute produces (write enable, byte address, store data) and the register-writeback fields. Owns the word-organised data RAM. Performs byte/halfword/word stores with lane enables, and loads with alignment and sign/zero extension. Returns a registered writeback packet to the writeback stage.

---
 rtl/memory_stage.sv | 191 +++++++++++++++++++
 tb/tb_memory_stage.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// memory_stage: load/store stage between execute and writeback.
//
// Accepts one request per cycle from execute. Loads take two cycles because
// the data RAM has a registered read. The stage owns a word-organised data RAM
// built from four byte lanes. Stores write selected lanes. Loads align the
// addressed lane and then sign- or zero-extend it. Each accepted request
// produces one registered writeback packet.
//
// Ports:
//   clk_i, rstn_i            clock, asynchronous active-low reset
//   valid_i / ready_o        request handshake from execute
//   memory_write_enable_i    request is a store (takes precedence over read)
//   memory_read_enable_i     request is a load
//   funct3_i                 access size / signedness (instr[14:12])
//   memory_addr_i            byte address
//   memory_write_data_i      store data
//   alu_data_i               result for non-memory instructions
//   rd_addr_i, rd_write_enable_i  destination register fields
//   valid_o                  one-cycle writeback pulse
//   rd_addr_o, rd_write_enable_o, rd_data_o  writeback packet
//   access_error_o           misaligned or illegal funct3, qualified by valid_o
module memory_stage #(
    parameter int XLEN     = 32,
    parameter int MEM_SIZE = 1024
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic            memory_write_enable_i,
    input  logic            memory_read_enable_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] memory_addr_i,
    input  logic [XLEN-1:0] memory_write_data_i,
    input  logic [XLEN-1:0] alu_data_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            rd_write_enable_i,
    output logic            valid_o,
    output logic [4:0]      rd_addr_o,
    output logic            rd_write_enable_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic            access_error_o
);
    localparam int AW = $clog2(MEM_SIZE);

    typedef enum logic {IDLE, LOAD} state_t;
    state_t state_reg;

    // Load context carried from acceptance into the LOAD cycle
    logic [2:0]      pend_funct3_reg;
    logic [1:0]      pend_lane_reg;
    logic [4:0]      pend_rd_addr_reg;
    logic            pend_rd_we_reg;

    logic [AW-1:0]   word_idx;
    logic [1:0]      lane;
    logic            is_store, is_load;
    logic            store_err, load_err, access_err;
    logic [3:0]      byte_en;
    logic [31:0]     store_word;
    logic            accept, ram_we, ram_re;
    logic [31:0]     ram_rdata;
    logic [31:0]     shifted;
    logic [XLEN-1:0] load_data;

    // Upper address bits are deliberately ignored (addresses wrap)
    logic unused_addr_bits;
    assign unused_addr_bits = ^memory_addr_i[XLEN-1:AW+2];

    assign word_idx = memory_addr_i[AW+1:2];
    assign lane     = memory_addr_i[1:0];
    assign is_store = memory_write_enable_i;
    assign is_load  = memory_read_enable_i && !memory_write_enable_i;
    assign ready_o  = (state_reg == IDLE);
    assign accept   = valid_i && ready_o;

    always_comb begin
        store_err  = 1'b0;
        byte_en    = 4'b0000;
        store_word = memory_write_data_i[31:0];
        case (funct3_i)
            3'b000: begin
                byte_en    = 4'b0001 << lane;
                store_word = {4{memory_write_data_i[7:0]}};
            end
            3'b001: begin
                store_err  = lane[0];
                byte_en    = lane[1] ? 4'b1100 : 4'b0011;
                store_word = {2{memory_write_data_i[15:0]}};
            end
            3'b010: begin
                store_err  = (lane != 2'b00);
                byte_en    = 4'b1111;
            end
            default: store_err = 1'b1;
        endcase
    end

    always_comb begin
        load_err = 1'b0;
        case (funct3_i)
            3'b000, 3'b100: load_err = 1'b0;
            3'b001, 3'b101: load_err = lane[0];
            3'b010:         load_err = (lane != 2'b00);
            default:        load_err = 1'b1;
        endcase
    end

    assign access_err = is_store ? store_err : (is_load ? load_err : 1'b0);
    assign ram_we     = accept && is_store && !store_err;
    assign ram_re     = accept && is_load && !load_err;

    // One RAM per byte lane so each lane's write enable is independent
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [MEM_SIZE];
            logic [7:0] q_reg;
            always_ff @(posedge clk_i) begin
                if (ram_we && byte_en[gi])
                    mem[word_idx] <= store_word[gi*8 +: 8];
                if (ram_re)
                    q_reg <= mem[word_idx];
            end
            assign ram_rdata[gi*8 +: 8] = q_reg;
        end
    endgenerate

    // Move the addressed byte/halfword down to bit 0, then extend
    assign shifted = ram_rdata >> {pend_lane_reg, 3'b000};

    always_comb begin
        case (pend_funct3_reg)
            3'b000:  load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg         <= IDLE;
            valid_o           <= 1'b0;
            rd_addr_o         <= '0;
            rd_write_enable_o <= 1'b0;
            rd_data_o         <= '0;
            access_error_o    <= 1'b0;
            pend_funct3_reg   <= '0;
            pend_lane_reg     <= '0;
            pend_rd_addr_reg  <= '0;
            pend_rd_we_reg    <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (is_load && !load_err) begin
                            // Packet fields keep their old values until the load completes
                            state_reg        <= LOAD;
                            pend_funct3_reg  <= funct3_i;
                            pend_lane_reg    <= lane;
                            pend_rd_addr_reg <= rd_addr_i;
                            pend_rd_we_reg   <= rd_write_enable_i;
                        end else begin
                            valid_o        <= 1'b1;
                            rd_addr_o      <= rd_addr_i;
                            access_error_o <= access_err;
                            if (is_store || is_load) begin
                                rd_write_enable_o <= 1'b0;
                                rd_data_o         <= '0;
                            end else begin
                                rd_write_enable_o <= rd_write_enable_i;
                                rd_data_o         <= alu_data_i;
                            end
                        end
                    end
                end
                LOAD: begin
                    state_reg         <= IDLE;
                    valid_o           <= 1'b1;
                    rd_addr_o         <= pend_rd_addr_reg;
                    rd_write_enable_o <= pend_rd_we_reg;
                    rd_data_o         <= load_data;
                    access_error_o    <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;
    logic        clk = 1'b0;
    logic        rstn;
    logic        valid_i;
    logic        ready;
    logic        we_i, re_i;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, alu;
    logic [4:0]  rd_i;
    logic        rdwe_i;
    logic        valid_o;
    logic [4:0]  rd_o;
    logic        rdwe_o;
    logic [31:0] data_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    memory_stage #(.XLEN(32), .MEM_SIZE(1024)) dut (
        .clk_i(clk), .rstn_i(rstn), .valid_i(valid_i), .ready_o(ready),
        .memory_write_enable_i(we_i), .memory_read_enable_i(re_i),
        .funct3_i(f3), .memory_addr_i(addr), .memory_write_data_i(wdata),
        .alu_data_i(alu), .rd_addr_i(rd_i), .rd_write_enable_i(rdwe_i),
        .valid_o(valid_o), .rd_addr_o(rd_o), .rd_write_enable_o(rdwe_o),
        .rd_data_o(data_o), .access_error_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic r, input logic [2:0] fn,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] al, input logic [4:0] rd, input logic rwe);
        valid_i = 1'b1; we_i = w; re_i = r; f3 = fn; addr = a;
        wdata = wd; alu = al; rd_i = rd; rdwe_i = rwe;
    endtask

    task automatic idle_in;
        valid_i = 1'b0; we_i = 1'b0; re_i = 1'b0;
    endtask

    // Single request, accepted at the next edge; inputs idle afterwards
    task automatic issue(input logic w, input logic r, input logic [2:0] fn,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] al, input logic [4:0] rd, input logic rwe);
        drive(w, r, fn, a, wd, al, rd, rwe);
        tick();
        idle_in();
    endtask

    task automatic resp(input string tag, input logic v, input logic [4:0] rd,
                        input logic rwe, input logic [31:0] d, input logic e);
        chk({tag, ".valid"}, {31'b0, valid_o}, {31'b0, v});
        chk({tag, ".rd"},    {27'b0, rd_o},    {27'b0, rd});
        chk({tag, ".we"},    {31'b0, rdwe_o},  {31'b0, rwe});
        chk({tag, ".data"},  data_o, d);
        chk({tag, ".err"},   {31'b0, err_o},   {31'b0, e});
    endtask

    // Good load: no output and ready low after acceptance, packet one cycle later
    task automatic load_chk(input string tag, input logic [2:0] fn, input logic [31:0] a,
                            input logic [4:0] rd, input logic [31:0] exp);
        issue(1'b0, 1'b1, fn, a, 32'h0, 32'h0, rd, 1'b1);
        chk({tag, ".v0"},    {31'b0, valid_o}, 32'd0);
        chk({tag, ".ready"}, {31'b0, ready},   32'd0);
        tick();
        resp(tag, 1'b1, rd, 1'b1, exp, 1'b0);
        $display("load  %s addr=%h data=%h", tag, a, data_o);
    endtask

    task automatic store(input string tag, input logic [2:0] fn, input logic [31:0] a,
                         input logic [31:0] wd);
        issue(1'b1, 1'b0, fn, a, wd, 32'h0, 5'd1, 1'b1);
        resp(tag, 1'b1, 5'd1, 1'b0, 32'h0, 1'b0);
        $display("store %s addr=%h data=%h", tag, a, wd);
    endtask

    initial begin
        rstn = 1'b0;
        idle_in();
        f3 = 3'b0; addr = '0; wdata = '0; alu = '0; rd_i = '0; rdwe_i = 1'b0;
        tick(); tick();
        resp("reset", 1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
        chk("reset.ready", {31'b0, ready}, 32'd1);
        rstn = 1'b1;
        tick();

        // Word store then load
        store("sw10", 3'b010, 32'h10, 32'hDEADBEEF);
        tick();
        chk("idle.valid", {31'b0, valid_o}, 32'd0);
        chk("idle.hold", data_o, 32'h0);
        load_chk("lw10", 3'b010, 32'h10, 5'd6, 32'hDEADBEEF);

        // Byte store and signed/unsigned byte loads
        store("sw10b", 3'b010, 32'h10, 32'h11223344);
        store("sb13", 3'b000, 32'h13, 32'hAAAAAA80);
        load_chk("lw10b", 3'b010, 32'h10, 5'd7, 32'h80223344);
        load_chk("lb13", 3'b000, 32'h13, 5'd8, 32'hFFFFFF80);
        load_chk("lbu13", 3'b100, 32'h13, 5'd9, 32'h00000080);
        load_chk("lb10", 3'b000, 32'h10, 5'd9, 32'h00000044);

        // Halfword store and loads
        store("sw20", 3'b010, 32'h20, 32'hCAFEF00D);
        store("sh22", 3'b001, 32'h22, 32'h12348001);
        load_chk("lh22", 3'b001, 32'h22, 5'd10, 32'hFFFF8001);
        load_chk("lhu22", 3'b101, 32'h22, 5'd11, 32'h00008001);
        load_chk("lw20", 3'b010, 32'h20, 5'd12, 32'h8001F00D);
        load_chk("lh20", 3'b001, 32'h20, 5'd12, 32'hFFFFF00D);

        // Access errors: single-cycle response, no write enable, RAM untouched
        store("sw00", 3'b010, 32'h00, 32'h01234567);
        issue(1'b0, 1'b1, 3'b010, 32'h02, 32'h0, 32'h0, 5'd13, 1'b1);
        resp("lw02err", 1'b1, 5'd13, 1'b0, 32'h0, 1'b1);
        chk("lw02err.ready", {31'b0, ready}, 32'd1);
        issue(1'b1, 1'b0, 3'b001, 32'h01, 32'hFFFFFFFF, 32'h0, 5'd14, 1'b1);
        resp("sh01err", 1'b1, 5'd14, 1'b0, 32'h0, 1'b1);
        issue(1'b0, 1'b1, 3'b011, 32'h00, 32'h0, 32'h0, 5'd15, 1'b1);
        resp("ld011err", 1'b1, 5'd15, 1'b0, 32'h0, 1'b1);
        issue(1'b1, 1'b0, 3'b011, 32'h00, 32'hFFFFFFFF, 32'h0, 5'd16, 1'b1);
        resp("st011err", 1'b1, 5'd16, 1'b0, 32'h0, 1'b1);
        load_chk("lw00", 3'b010, 32'h00, 5'd17, 32'h01234567);

        // Back-to-back with valid_i held: ADD, SW, LW, ADD
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'd5, 5'd3, 1'b1);
        tick();
        resp("b2b.add1", 1'b1, 5'd3, 1'b1, 32'd5, 1'b0);
        drive(1'b1, 1'b0, 3'b010, 32'h30, 32'h55AA55AA, 32'h0, 5'd2, 1'b1);
        tick();
        resp("b2b.sw", 1'b1, 5'd2, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 3'b010, 32'h30, 32'h0, 32'h0, 5'd7, 1'b1);
        tick();
        chk("b2b.gap", {31'b0, valid_o}, 32'd0);
        chk("b2b.ready0", {31'b0, ready}, 32'd0);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'd9, 5'd4, 1'b1);
        tick();
        resp("b2b.lw", 1'b1, 5'd7, 1'b1, 32'h55AA55AA, 1'b0);
        chk("b2b.ready1", {31'b0, ready}, 32'd1);
        tick();
        idle_in();
        resp("b2b.add2", 1'b1, 5'd4, 1'b1, 32'd9, 1'b0);
        tick();
        chk("b2b.end", {31'b0, valid_o}, 32'd0);
        chk("b2b.hold", data_o, 32'd9);

        // Non-memory with write enable low
        issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h12345678, 5'd20, 1'b0);
        resp("alu.nowe", 1'b1, 5'd20, 1'b0, 32'h12345678, 1'b0);

        // Both enables set: treated as a store
        issue(1'b1, 1'b1, 3'b010, 32'h40, 32'h00000077, 32'h0, 5'd21, 1'b1);
        resp("both", 1'b1, 5'd21, 1'b0, 32'h0, 1'b0);
        load_chk("lw40", 3'b010, 32'h40, 5'd22, 32'h00000077);

        // Address wrap modulo 4*MEM_SIZE
        store("sw1010", 3'b010, 32'h1010, 32'h600DF00D);
        load_chk("wrap", 3'b010, 32'h0010, 5'd23, 32'h600DF00D);

        // Reset while a load is pending
        issue(1'b0, 1'b1, 3'b010, 32'h10, 32'h0, 32'h0, 5'd24, 1'b1);
        chk("rstload.busy", {31'b0, ready}, 32'd0);
        rstn = 1'b0;
        #1;
        chk("rstload.ready", {31'b0, ready}, 32'd1);
        chk("rstload.valid", {31'b0, valid_o}, 32'd0);
        tick();
        rstn = 1'b1;
        tick();
        resp("rstload.after", 1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
        load_chk("postrst", 3'b010, 32'h10, 5'd25, 32'h600DF00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
